// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: operation codes, group bit and FSM state encoding shared by alu_seq and
// muldiv_iter.
package alu_seq_pkg;

  // op[4] selects the M-extension group; op[3:0] decodes base ops, op[2:0] decodes M ops.
  localparam int unsigned OpGrpBit = 4;

  // Base ops, op[4] = 0, decoded on op[3:0]
  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSlt  = 4'b0101;
  localparam logic [3:0] OpSll  = 4'b0110;
  localparam logic [3:0] OpSrl  = 4'b0111;
  localparam logic [3:0] OpSra  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;

  // M ops, op[4] = 1, decoded on op[2:0] (RISC-V funct3)
  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  // Control FSM
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'b00;
  localparam state_t StRun  = 2'b01;
  localparam state_t StDone = 2'b10;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative unsigned engine, one bit per cycle for XLEN cycles.
// Multiply: shift-add into {hi, lo}, lo starts as the multiplier.
// Divide: restoring division, hi is the partial remainder, lo shifts in quotient bits.
// Outputs expose next-state values so the final iteration's result is usable on the
// same edge that performs it.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   mag_a_i,
  input  logic [XLEN-1:0]   mag_b_i,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quot_o,
  output logic [XLEN-1:0]   rem_o,
  output logic              last_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            run_q, run_d, div_q, div_d;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            last;

  // Next-state for one multiply or divide step
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    last      = run_q && (cnt_q == CntW'(XLEN - 1));
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    div_d     = div_q;
    if (load_i) begin
      hi_d  = '0;
      lo_d  = mag_a_i;
      opb_d = mag_b_i;
      cnt_d = '0;
      run_d = 1'b1;
      div_d = is_div_i;
    end else if (run_q) begin
      if (div_q) begin
        // Borrow out means the divisor did not fit: restore.
        hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      cnt_d = cnt_q + CntW'(1);
      if (last) run_d = 1'b0;
    end
  end

  // Engine state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
    end
  end

  assign prod_o = {hi_d, lo_d};
  assign quot_o = lo_d;
  assign rem_o  = hi_d;
  assign last_o = last;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered multicycle ALU with optional RV32M/RV64M multiply/divide.
// Define ALU_SEQ_MULDIV_EN to build the iterative M-op engine; without it every M op
// completes in one cycle as illegal with a zero result.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d, illegal_q, illegal_d;
  logic [XLEN-1:0] base_res;
  logic            base_ill;
  logic [SHAMT_W-1:0] shamt;

  // M-group interface to the FSM
  logic            m_short, m_short_ill, m_load, run_last;
  logic [XLEN-1:0] m_short_res, run_res;

  // Single-cycle base ALU
  always_comb begin
    shamt    = b[SHAMT_W-1:0];
    base_res = '0;
    base_ill = 1'b0;
    case (op[3:0])
      OpAdd:   base_res = a + b;
      OpSub:   base_res = a - b;
      OpAnd:   base_res = a & b;
      OpOr:    base_res = a | b;
      OpXor:   base_res = a ^ b;
      OpSlt:   base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu:  base_res = {{(XLEN-1){1'b0}}, a < b};
      OpSll:   base_res = a << shamt;
      OpSrl:   base_res = a >> shamt;
      OpSra:   base_res = $unsigned($signed(a) >>> shamt);
      default: base_ill = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic              a_sgn, b_sgn, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b, quot, rem, quot_fix, rem_fix;
  logic [2*XLEN-1:0] prod, prod_fix;

  // Operand magnitudes, short-circuit detection and result sign fix-up
  always_comb begin
    a_sgn    = (op[2:0] == OpMulh) || (op[2:0] == OpMulhsu) ||
               (op[2:0] == OpDiv)  || (op[2:0] == OpRem);
    b_sgn    = (op[2:0] == OpMulh) || (op[2:0] == OpDiv) || (op[2:0] == OpRem);
    sa       = a_sgn & a[XLEN-1];
    sb       = b_sgn & b[XLEN-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    div_zero = (b == '0);
    div_ovf  = ((op[2:0] == OpDiv) || (op[2:0] == OpRem)) && (a == MinInt) && (b == '1);
    m_short  = op[2] & (div_zero | div_ovf);
    m_short_ill = 1'b0;
    // op[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) m_short_res = op[1] ? a : '1;
    else          m_short_res = op[1] ? '0 : MinInt;
    m_load   = start && (state_q == StIdle) && op[OpGrpBit] && !m_short;

    f3_d   = f3_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    if (m_load) begin
      f3_d   = op[2:0];
      neg_d  = sa ^ sb;
      rneg_d = sa;
    end

    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -quot : quot;
    rem_fix  = rneg_q ? -rem : rem;
    case (f3_q)
      OpMul:           run_res = prod_fix[XLEN-1:0];
      OpDiv, OpDivu:   run_res = quot_fix;
      OpRem, OpRemu:   run_res = rem_fix;
      default:         run_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // Latched op and sign flags for the in-flight M op
  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      f3_q   <= f3_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (m_load),
    .is_div_i (op[2]),
    .mag_a_i  (mag_a),
    .mag_b_i  (mag_b),
    .prod_o   (prod),
    .quot_o   (quot),
    .rem_o    (rem),
    .last_o   (run_last)
  );
`else
  // Every M op retires immediately as illegal.
  assign m_short     = 1'b1;
  assign m_short_ill = 1'b1;
  assign m_short_res = '0;
  assign m_load      = 1'b0;
  assign run_last    = 1'b0;
  assign run_res     = '0;
`endif

  // Control FSM and result capture; result only moves on the edge entering DONE
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (!op[OpGrpBit]) begin
            state_d   = StDone;
            result_d  = base_res;
            illegal_d = base_ill;
          end else if (m_short) begin
            state_d   = StDone;
            result_d  = m_short_res;
            illegal_d = m_short_ill;
          end else begin
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        if (run_last) begin
          state_d   = StDone;
          result_d  = run_res;
          illegal_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    zero_d = (result_d == '0);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign illegal = (state_q == StDone) && illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (XLEN = 32).
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  logic        zero, busy, done, illegal;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .XLEN (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .zero    (zero),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, count cycles to done, then check result/flags and return to idle.
  // poke > 0 drives a stray start during that cycle of the operation.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp_res,
                        input logic exp_ill, input int exp_lat, input int poke);
    int n;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (n == poke) begin
        start = 1'b1; op = 5'b00000; a = 32'd1; b = 32'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    if (!busy) busy_ok = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " zero"}, 64'(zero), 64'(exp_res == 32'd0));
    check({tag, " illegal"}, 64'(illegal), 64'(exp_ill));
    check({tag, " busy"}, 64'(busy_ok), 64'(1));
    @(posedge clk); #1;
    check({tag, " idle after"}, {29'd0, done, busy, illegal, result}, {32'd0, exp_res});
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 5'b00000; a = 32'd1; b = 32'd2;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", {28'd0, zero, busy, done, illegal, result}, {28'd0, 4'b1000, 32'd0});
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    run_op("SLT",  5'b00101, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1, 0);
    run_op("SLTU", 5'b01001, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1, 0);
    run_op("SRA",  5'b01000, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1, 0);
    run_op("SUB",  5'b00001, 32'd5, 32'd5, 32'd0, 1'b0, 1, 0);
    run_op("ADD",  5'b00000, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 1, 0);
    run_op("SLL",  5'b00110, 32'd1, 32'h21, 32'd2, 1'b0, 1, 0);
    run_op("SRL",  5'b00111, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1, 0);
    run_op("XOR",  5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1, 0);
    run_op("BAD",  5'b01010, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);

`ifdef ALU_SEQ_MULDIV_EN
    run_op("MULH",   5'b10001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 33, 0);
    run_op("MUL",    5'b10000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 1'b0, 33, 0);
    run_op("MULHU",  5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 0);
    run_op("MULHSU", 5'b10010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 33, 0);
    run_op("DIV0",   5'b10100, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, 1, 0);
    run_op("REM0",   5'b10110, 32'd7, 32'd0, 32'd7, 1'b0, 1, 0);
    run_op("DIVOVF", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1, 0);
    run_op("REMOVF", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1, 0);
    run_op("DIV",    5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33, 0);
    run_op("REM",    5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33, 0);
    run_op("DIVU",   5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, 33, 10);
    run_op("REMU",   5'b10111, 32'd100, 32'd7, 32'd2, 1'b0, 33, 0);

    // Reset during cycle 5 of a MUL aborts it.
    begin
      bit saw_done;
      @(negedge clk);
      start = 1'b1; op = 5'b10000; a = 32'd5; b = 32'd6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort busy", 64'(busy), 64'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort reset state", {28'd0, zero, busy, done, illegal, result},
            {28'd0, 4'b1000, 32'd0});
      saw_done = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done || busy) saw_done = 1'b1;
      end
      check("abort no done", 64'(saw_done), 64'(0));
    end
`else
    run_op("MUL off", 5'b10000, 32'hFFFFFFFE, 32'd3, 32'd0, 1'b1, 1, 0);
    run_op("DIV off", 5'b10100, 32'd7, 32'd0, 32'd0, 1'b1, 1, 0);
`endif

    run_op("ADD again", 5'b00000, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, multicycle successor to the single-cycle ALU in the multicycle RISC-V core, generalised to XLEN bits and extended with the RV32M/RV64M multiply/divide operations. Sits in the EX state of the core's control FSM: the controller issues `start` with an operation, then waits for `done` before advancing. Base integer ops complete in one cycle. MUL/DIV family ops run an iterative engine for XLEN cycles.

## Interface
- `XLEN`, default 32: datapath width, 32 or 64.
- `SHAMT_W`, default `$clog2(XLEN)`: shift-amount width; derived, do not override.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `op`  in  5  operation.
  - `op[4]`=0 selects base ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 1001 SLTU (unsigned), 0110 SLL, 0111 SRL, 1000 SRA.
  - `op[4]`=1 selects M ops by `op[2:0]`=funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `a`  in  XLEN  operand A, rs1; sampled at accept.
- `b`  in  XLEN  operand B, rs2 or imm; sampled at accept.
- `result`  out  XLEN  registered result; held until the next accept.
- `zero`  out  1  registered (`result`==0); updated together with `result`.
- `busy`  out  1  high while an operation is in flight, i.e. state≠IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `illegal`  out  1  pulses with `done` for an unsupported op.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→DONE: base op, unused base code, or M-op short-circuit.
  - IDLE→RUN: other M ops.
  - RUN→DONE: after XLEN iterations.
  - DONE→IDLE: unconditional.
- Base ops:
  - Arithmetic is modulo 2^XLEN.
  - Shifts use `b[SHAMT_W-1:0]`.
  - SRA sign-fills from `a[XLEN-1]`.
  - SLT/SLTU write 1 or 0, zero-extended.
- Unused base codes 1010–1111 give `result`=0 and `illegal`=1.
- MUL family:
  - Operands are converted to magnitudes per signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Unsigned shift-add runs one bit per RUN cycle into a 2·XLEN product.
  - The product is negated at RUN→DONE if the signs differ.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- DIV family:
  - Restoring division runs one quotient bit per RUN cycle on magnitudes.
  - Quotient sign = sign(a)^sign(b).
  - Remainder sign = sign(a).
- Short-circuits, which go to DONE in cycle 1:
  - Divide by zero: quotient is all-ones; remainder is `a`.
  - Signed overflow (min_int / −1): quotient is min_int; remainder is 0.
- `start` while `busy`=1 is ignored; the in-flight op is unaffected and the request is not queued.
- `start` in the DONE cycle is also ignored, because `busy`=1 there.

## Timing
- Accept at edge 0 (`start`=1, IDLE).
- Base op: `done`=1 in cycle 1; next accept possible in cycle 2.
- M op: RUN occupies cycles 1..XLEN; `done`=1 in cycle XLEN+1, which is cycle 33 for XLEN=32.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- `result` and `zero` change only on the edge entering DONE.
- Reset values: state IDLE, `result`=0, `zero`=1, `busy`=0, `done`=0, `illegal`=0, engine registers 0.
- Reset mid-RUN aborts the operation; no `done` is produced for it.
- Reset wins over `start` in the same cycle.

## Configuration
- Macro: `ALU_SEQ_MULDIV_EN`.
- Defined: the M ops are implemented as above.
- Undefined:
  - The iterative engine is not instantiated.
  - Any `op[4]`=1 goes IDLE→DONE with `result`=0, `zero`=1, `illegal`=1.
  - Base-op behaviour and timing are unchanged.

## Structure
- Package `alu_seq_pkg` holds:
  - localparams for every `op` code;
  - the `op[4]` group bit;
  - the FSM state typedef (IDLE/RUN/DONE).
- One sub-module, `muldiv_iter`:
  - inputs: magnitudes, mul/div select, load pulse;
  - outputs: 2·XLEN product, or quotient and remainder, plus iteration-count done.
- `muldiv_iter` is instantiated only under `ALU_SEQ_MULDIV_EN`.
- Sign fix-up and short-circuit detection stay in the top level.

## Test plan
- SLT vs SLTU: a=0xFFFFFFFF, b=1.
  - SLT → `result`=1; SLTU → `result`=0.
  - `done` is high in cycle 1 for both.
- SRA: a=0x80000000, b=0x24 (shamt 4) → 0xF8000000.
- SUB: a=b=5 → `result`=0, `zero`=1.
- MULH: a=0xFFFFFFFE (−2), b=3 → 0xFFFFFFFF.
  - MUL with the same operands → 0xFFFFFFFA.
  - `done` is in cycle 33.
  - `busy` is high for cycles 1–33.
- Divide by zero and overflow:
  - DIV a=7, b=0 → 0xFFFFFFFF; REM a=7, b=0 → 7. Both have `done` in cycle 1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Robustness:
  - `start` pulsed at cycle 10 of a DIVU is ignored.
  - `reset` at cycle 5 of a MUL → no `done`, outputs at reset values, next accept works.
  - Without the macro, MUL → `illegal`=1, `result`=0 in cycle 1.
